// File: rtl/mul_arbiter.sv
// Two-requester arbiter in front of one shared sequential multiplier.
// Define MUL_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to requester 0.
module mul_arbiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        Req1,
    input  logic [31:0] A0,
    input  logic [31:0] B0,
    input  logic [31:0] A1,
    input  logic [31:0] B1,
    output logic        Gnt0,
    output logic        Gnt1,
    output logic        Done0,
    output logic        Done1,
    output logic [63:0] P,
    output logic        Mul_Start,
    output logic [31:0] Mul_A,
    output logic [31:0] Mul_B,
    input  logic        Mul_Done,
    input  logic [63:0] Mul_P,
    output logic        Busy
);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e state;
    logic   winner;
    logic   pick;

`ifdef MUL_ARB_RR_EN
    logic ptr;
`endif

    // pick is only consumed when at least one request is present
    always_comb begin
`ifdef MUL_ARB_RR_EN
        pick = (Req0 && Req1) ? ptr : Req1;
`else
        pick = !Req0;
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= StIdle;
            winner    <= 1'b0;
            Gnt0      <= 1'b0;
            Gnt1      <= 1'b0;
            Done0     <= 1'b0;
            Done1     <= 1'b0;
            Mul_Start <= 1'b0;
            Busy      <= 1'b0;
            P         <= '0;
            Mul_A     <= '0;
            Mul_B     <= '0;
`ifdef MUL_ARB_RR_EN
            ptr       <= 1'b0;
`endif
        end else begin
            Gnt0      <= 1'b0;
            Gnt1      <= 1'b0;
            Done0     <= 1'b0;
            Done1     <= 1'b0;
            Mul_Start <= 1'b0;
            case (state)
                StIdle: begin
                    if (Req0 || Req1) begin
                        winner <= pick;
                        Mul_A  <= pick ? A1 : A0;
                        Mul_B  <= pick ? B1 : B0;
                        Gnt0   <= !pick;
                        Gnt1   <= pick;
                        Busy   <= 1'b1;
                        state  <= StGrant;
`ifdef MUL_ARB_RR_EN
                        ptr    <= !pick;
`endif
                    end
                end
                StGrant: begin
                    Mul_Start <= 1'b1;
                    state     <= StIssue;
                end
                StIssue: begin
                    state <= StWait;
                end
                StWait: begin
                    // no timeout: the multiplier is trusted to answer eventually
                    if (Mul_Done) begin
                        P     <= Mul_P;
                        Done0 <= !winner;
                        Done1 <= winner;
                        state <= StResp;
                    end
                end
                StResp: begin
                    Busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

    a_gnt_onehot : assert property (@(posedge Clk) disable iff (Reset) !(Gnt0 && Gnt1));
    a_done_onehot : assert property (@(posedge Clk) disable iff (Reset) !(Done0 && Done1));
    a_busy_state : assert property (@(posedge Clk) disable iff (Reset)
        Busy == (state != StIdle));

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have ports: Clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: Req0, Req1  input  1 each  multiply request from requester 0/1.
REQ-004 SHALL have ports: A0, B0, A1, B1  input  32 each  operands of requester 0/1.
REQ-005 SHALL have ports: Gnt0, Gnt1  output  1 each  one-cycle grant pulse; operands sampled.
REQ-006 SHALL have ports: Done0, Done1  output  1 each  one-cycle result-valid pulse.
REQ-007 SHALL have ports: P  output  64  product; valid while Done0/Done1 high, held until next capture.
REQ-008 SHALL have ports: Mul_Start  output  1  one-cycle start pulse to the shared sequential multiplier.
REQ-009 SHALL have ports: Mul_A, Mul_B  output  32 each  registered operands driven to the multiplier.
REQ-010 SHALL have ports: Mul_Done  input  1  multiplier result-ready pulse.
REQ-011 SHALL have ports: Mul_P  input  64  multiplier product, valid when Mul_Done=1.
REQ-012 SHALL have ports: Busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, GRANT, ISSUE, WAIT, RESP; all outputs registered.
REQ-014 IDLE: if Req0 or Req1, select winner, latch its operands into Mul_A/Mul_B and winner index, go GRANT; else stay.
REQ-015 GRANT: Gnt of winner =1 for exactly this cycle; go ISSUE.
REQ-016 ISSUE: Mul_Start=1 for exactly this cycle; go WAIT.
REQ-017 WAIT: on Mul_Done=1 capture Mul_P into P, go RESP; otherwise stay, no timeout.
REQ-018 RESP: Done of winner =1 for exactly this cycle; go IDLE.
REQ-019 Mul_Done outside WAIT SHALL be ignored; P unchanged.
REQ-020 Requests arriving outside IDLE SHALL wait (not lost) as long as Req is held; requester holds Req and operands until its Gnt, may drop Req after.
REQ-021 Latency from Req sampled in IDLE to Mul_Start SHALL be 2 cycles; from Mul_Done to Done pulse 1 cycle.
REQ-022 Mul_A/Mul_B SHALL stay stable from GRANT until the next IDLE selection.
REQ-023 Only one of Gnt0/Gnt1 and one of Done0/Done1 SHALL be high in any cycle; back-to-back jobs SHALL have at least one IDLE cycle between RESP and next GRANT.
REQ-024 Winner selection with both requests: per Configuration; single request always wins.

Reset
REQ-025 Reset high SHALL asynchronously force IDLE, Gnt0/1, Done0/1, Mul_Start, Busy =0, P, Mul_A, Mul_B =0, priority pointer to requester 0.
REQ-026 Reset mid-operation SHALL abort the job with no Done pulse; a Mul_Done arriving after Reset release SHALL be ignored (REQ-019).

Configuration
REQ-027 Macro MUL_ARB_RR_EN defined: round-robin; pointer names favoured requester, flips to the other one when a job is granted; tie goes to pointer.
REQ-028 MUL_ARB_RR_EN undefined: fixed priority, Req0 always wins ties; no pointer register.

Verification
REQ-029 Req0 only, A0=3, B0=5; model Mul_Done 32 cycles after Mul_Start, Mul_P=15 -> Gnt0 at cycle 1, Mul_Start cycle 2, Done0 with P=15 one cycle after Mul_Done, Busy low afterwards.
REQ-030 Req0 and Req1 held together, A0=2,B0=7,A1=0xFFFFFFFF,B1=2 -> RR_EN: order 0,1,0,1 with P=14 then 0x1FFFFFFFE; without RR_EN: requester 0 served repeatedly while Req0 held, Req1 never granted.
REQ-031 Req1 asserted during WAIT of requester 0 job -> Req1 granted in first IDLE after Done0, no pulse lost or duplicated.
REQ-032 Spurious Mul_Done in IDLE and ISSUE with Mul_P=0xDEAD -> P unchanged, no Done pulse, state unchanged.
REQ-033 Reset asserted 10 cycles into WAIT, Mul_Done pulsed 5 cycles after release -> all outputs 0 immediately, no Done, next Req served normally with pointer at 0.
